// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns an EX-stage load/store into a req/ack transaction on
// a word-wide data memory and holds the pipeline frozen until it completes.
module mem_access_stage #(
    parameter logic [31:0] ADDR_BASE = 32'd1024,
    parameter int          ADDR_W    = 16,
    parameter int          TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_en_in,
    input  logic              MEM_R_en_in,
    input  logic              MEM_W_en_in,
    input  logic [31:0]       ALU_result_in,
    input  logic [31:0]       Val_Rm_in,
    input  logic [3:0]        Dest_in,
    output logic              WB_en,
    output logic              MEM_R_en,
    output logic [31:0]       ALU_result,
    output logic [3:0]        Dest,
    output logic [31:0]       Mem_read_value,
    output logic              freeze,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rd_value_q, rd_value_d;
    logic              mem_err_q, mem_err_d;

    logic        access;
    logic [31:0] addr_diff;
    logic        unused_addr_bits;

    assign WB_en      = WB_en_in;
    assign MEM_R_en   = MEM_R_en_in;
    assign ALU_result = ALU_result_in;
    assign Dest       = Dest_in;

    assign access    = MEM_R_en_in | MEM_W_en_in;
    // Wrap-around subtraction; only the word-address bits reach the bus.
    assign addr_diff = ALU_result_in - ADDR_BASE;
    assign unused_addr_bits = ^{addr_diff[31:ADDR_W+2], addr_diff[1:0]};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_value_d  = rd_value_q;
        mem_err_d   = 1'b0;
        freeze      = 1'b0;

        case (state_q)
            IDLE: begin
                freeze = access;
                if (access) begin
                    mem_addr_d  = addr_diff[ADDR_W+1:2];
                    mem_we_d    = MEM_W_en_in & ~MEM_R_en_in;
                    mem_wdata_d = Val_Rm_in;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                freeze = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                // An ack on the final wait cycle takes priority over the timeout.
                if (mem_ack) begin
                    if (!mem_we_q) rd_value_d = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    if (!mem_we_q) rd_value_d = 32'hDEAD_BEEF;
                    mem_req_d = 1'b0;
                    mem_err_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_value_q  <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_value_q  <= rd_value_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign Mem_read_value = rd_value_q;
    assign mem_err        = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed corner cases plus random
// loads/stores scored against a transaction-level model of the stage.
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        WB_en_in = 1'b0, MEM_R_en_in = 1'b0, MEM_W_en_in = 1'b0;
    logic [31:0] ALU_result_in = '0, Val_Rm_in = '0;
    logic [3:0]  Dest_in = '0;
    logic        WB_en, MEM_R_en, freeze, mem_req, mem_we, mem_err;
    logic [31:0] ALU_result, Mem_read_value, mem_wdata;
    logic [3:0]  Dest;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd_model = '0;

    mem_access_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .WB_en_in(WB_en_in), .MEM_R_en_in(MEM_R_en_in), .MEM_W_en_in(MEM_W_en_in),
        .ALU_result_in(ALU_result_in), .Val_Rm_in(Val_Rm_in), .Dest_in(Dest_in),
        .WB_en(WB_en), .MEM_R_en(MEM_R_en), .ALU_result(ALU_result), .Dest(Dest),
        .Mem_read_value(Mem_read_value), .freeze(freeze),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One memory op; ack_dly = BUSY cycles before ack, or >= T for no ack at all.
    task automatic mem_op(input logic r, input logic w, input logic [31:0] alu,
                          input logic [31:0] val, input logic [3:0] dst,
                          input int ack_dly, input logic [31:0] rdata);
        int          fz, busy;
        bit          done, acked;
        int          exp_fz;
        logic        exp_we;
        logic [15:0] exp_addr;
        exp_we   = w && !r;
        exp_addr = 16'((alu - 32'd1024) / 4);
        acked    = (ack_dly >= 0) && (ack_dly <= T - 1);
        exp_fz   = acked ? ack_dly + 2 : T + 1;
        MEM_R_en_in = r; MEM_W_en_in = w; WB_en_in = r;
        ALU_result_in = alu; Val_Rm_in = val; Dest_in = dst;
        fz = 0; busy = 0; done = 0;
        for (int c = 0; c < T + 8 && !done; c++) begin
            mem_ack   = mem_req && (busy == ack_dly);
            mem_rdata = mem_ack ? rdata : $urandom;
            @(negedge clk);
            if (c == 0) begin
                check("pass_alu", ALU_result, alu);
                check("pass_dest", {28'd0, Dest}, {28'd0, dst});
                check("pass_ren", {31'd0, MEM_R_en}, {31'd0, r});
            end
            if (mem_req) begin
                check("req_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
                check("req_we", {31'd0, mem_we}, {31'd0, exp_we});
                if (exp_we) check("req_wdata", mem_wdata, val);
                busy++;
            end
            if (freeze) fz++;
            else if (c > 0) begin
                done = 1;
                if (r) rd_model = acked ? rdata : 32'hDEAD_BEEF;
                check("done_rdval", Mem_read_value, rd_model);
                check("done_err", {31'd0, mem_err}, {31'd0, !acked});
                check("done_req", {31'd0, mem_req}, 32'd0);
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        if (!done) check("done_seen", 32'd0, 32'd1);
        check("freeze_cycles", fz, exp_fz);
        MEM_R_en_in = 1'b0; MEM_W_en_in = 1'b0;
        @(negedge clk);
        check("err_cleared", {31'd0, mem_err}, 32'd0);
        check("rdval_hold", Mem_read_value, rd_model);
        check("idle_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Non-memory instruction with a stray ack pulse: nothing may move.
    task automatic non_mem_op(input logic wb, input logic [31:0] alu, input logic [3:0] dst);
        MEM_R_en_in = 1'b0; MEM_W_en_in = 1'b0; WB_en_in = wb;
        ALU_result_in = alu; Dest_in = dst;
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        check("nm_freeze", {31'd0, freeze}, 32'd0);
        check("nm_wb", {31'd0, WB_en}, {31'd0, wb});
        check("nm_dest", {28'd0, Dest}, {28'd0, dst});
        check("nm_alu", ALU_result, alu);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("nm_req", {31'd0, mem_req}, 32'd0);
        check("nm_rdval", Mem_read_value, rd_model);
        check("nm_err", {31'd0, mem_err}, 32'd0);
        check("nm_freeze2", {31'd0, freeze}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst = 1'b0;
        #10;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdval", Mem_read_value, 32'd0);
        check("rst_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        mem_op(1'b1, 1'b0, 32'd1028, 32'd0, 4'd3, 0, 32'h1234_5678);
        mem_op(1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D, 4'd0, 3, 32'h0);
        mem_op(1'b1, 1'b0, 32'd2000, 32'd0, 4'd5, T + 5, 32'h0);
        mem_op(1'b1, 1'b0, 32'd1100, 32'd0, 4'd2, T - 1, 32'hA5A5_0F0F);
        mem_op(1'b1, 1'b1, 32'd0, 32'h1111_2222, 4'd1, 1, 32'h0BAD_CAFE);
        mem_op(1'b0, 1'b1, 32'd3000, 32'h5555_AAAA, 4'd0, T + 1, 32'h0);
        non_mem_op(1'b1, 32'h0000_0042, 4'h7);

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0)
                non_mem_op(1'($urandom), $urandom, 4'($urandom));
            else
                mem_op(kind != 2, kind != 1, $urandom, $urandom, 4'($urandom),
                       $urandom_range(0, T + 1), $urandom);
        end

        // Reset in the middle of an access drops it without completion.
        MEM_R_en_in = 1'b1; ALU_result_in = 32'd1500; WB_en_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b0;
        MEM_R_en_in = 1'b0;
        #1;
        rd_model = '0;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_rdval", Mem_read_value, 32'd0);
        check("mid_rst_freeze", {31'd0, freeze}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFEED_FACE;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("post_rst_req", {31'd0, mem_req}, 32'd0);
        check("post_rst_rdval", Mem_read_value, 32'd0);
        check("post_rst_err", {31'd0, mem_err}, 32'd0);
        check("post_rst_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk); #1;
        mem_op(1'b1, 1'b0, 32'd1032, 32'd0, 4'd9, 2, 32'h7777_1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
